// File: rtl/ksa_share_arbiter_pkg.sv
// Shared types, constants and the round-robin search used by the adder-sharing arbiter.
package ksa_share_arbiter_pkg;

  localparam int KSA_W    = 5;
  localparam int RR_MAX   = 8;
  localparam int RR_IDX_W = 3;

  typedef enum logic {ST_EMPTY, ST_FULL} state_e;

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // First valid index at or above ptr, wrapping at n; ptr is assumed < n.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] valid,
                                       input logic [RR_IDX_W-1:0] ptr,
                                       input int n);
    rr_pick_t r;
    int       j;
    r = '0;
    for (int k = 0; k < RR_MAX; k++) begin
      j = int'(ptr) + k;
      if (j >= n) j = j - n;
      if ((k < n) && !r.found && valid[j[RR_IDX_W-1:0]]) begin
        r.found = 1'b1;
        r.idx   = j[RR_IDX_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ksa_share_arbiter_if.sv
// Requester and result handshake bundle of the adder-sharing arbiter.
interface ksa_share_arbiter_if
  import ksa_share_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = KSA_W,
  parameter int ID_W  = $clog2(N_REQ),
  parameter int CNT_W = 16
);
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ*W-1:0] req_a;
  logic [N_REQ*W-1:0] req_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [W-1:0]       rsp_sum;
  logic               rsp_cout;
  logic [ID_W-1:0]    rsp_id;
  logic [CNT_W-1:0]   op_count;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id, op_count
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id, op_count
  );
endinterface

// File: rtl/ksa_share_arbiter_ksa4.sv
// 5-bit Kogge-Stone adder core: three prefix levels (span 1, 2, 4), carry-in tied to 0.
module ksa4
  import ksa_share_arbiter_pkg::*;
(
  input  logic [KSA_W-1:0] a,
  input  logic [KSA_W-1:0] b,
  output logic [KSA_W-1:0] sum,
  output logic             cout
);
  logic [KSA_W-1:0] g0, p0, g1, g2, g3;
  logic [KSA_W-1:2] p1;
  logic             p2_top;

  // Prefix tree; g3[i] is the carry out of bit i.
  always_comb begin
    g0 = a & b;
    p0 = a ^ b;
    g1 = g0;
    p1 = '0;
    for (int i = 1; i < KSA_W; i++) g1[i] = g0[i] | (p0[i] & g0[i-1]);
    for (int i = 2; i < KSA_W; i++) p1[i] = p0[i] & p0[i-1];
    g2 = g1;
    for (int i = 2; i < KSA_W; i++) g2[i] = g1[i] | (p1[i] & g1[i-2]);
    p2_top = p1[4] & p1[2];
    g3 = g2;
    g3[4] = g2[4] | (p2_top & g2[0]);
    sum = p0;
    for (int i = 1; i < KSA_W; i++) sum[i] = p0[i] ^ g3[i-1];
    cout = g3[KSA_W-1];
  end
endmodule

// File: rtl/ksa_share_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid requester at or above ptr, with wrap.
module rr_picker
  import ksa_share_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
)(
  input  logic [N_REQ-1:0] valid,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  grant,
  output logic             found
);
  rr_pick_t pick;
  logic     unused_idx_bits;

  // Widen to the package's fixed search width and narrow the result back.
  always_comb begin
    pick  = rr_pick(RR_MAX'(valid), RR_IDX_W'(ptr), N_REQ);
    grant = pick.idx[ID_W-1:0];
    found = pick.found;
  end

  assign unused_idx_bits = ^pick.idx;
endmodule

// File: rtl/ksa_share_arbiter.sv
// Round-robin arbiter time-sharing one Kogge-Stone adder with a single-entry result stage.
module ksa_share_arbiter
  import ksa_share_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = KSA_W,
  parameter int ID_W  = $clog2(N_REQ),
  parameter int CNT_W = 16
)(
  input logic               clk,
  input logic               rst,
  ksa_share_arbiter_if.slave bus
);
  state_e           state_p1, state_d;
  logic [ID_W-1:0]  ptr_p1;
  logic [ID_W-1:0]  grant_p0;
  logic             found_p0;
  logic             accept_p0;
  logic [W-1:0]     a_p0, b_p0, sum_p0;
  logic             cout_p0;
  logic [W-1:0]     sum_p1;
  logic             cout_p1;
  logic [ID_W-1:0]  id_p1;
  logic [CNT_W-1:0] cnt_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [ID_W-1:0] ptr_after(input logic [ID_W-1:0] g);
    return (g == ID_W'(N_REQ - 1)) ? '0 : g + 1'b1;
  endfunction

  rr_picker #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
    .valid (bus.req_valid),
    .ptr   (ptr_p1),
    .grant (grant_p0),
    .found (found_p0)
  );

  // Stage p0: select the winner's operands for the shared adder.
  always_comb begin
    a_p0 = bus.req_a[int'(grant_p0)*W +: W];
    b_p0 = bus.req_b[int'(grant_p0)*W +: W];
  end

  ksa4 u_add (
    .a    (a_p0),
    .b    (b_p0),
    .sum  (sum_p0),
    .cout (cout_p0)
  );

  // Grant and output-stage next state; a draining slot may be refilled in the same cycle.
  always_comb begin
    accept_p0     = found_p0 && !rst && ((state_p1 == ST_EMPTY) || bus.rsp_ready);
    bus.req_ready = '0;
    if (accept_p0) bus.req_ready[grant_p0] = 1'b1;
    state_d = state_p1;
    if (accept_p0)                                state_d = ST_FULL;
    else if (state_p1 == ST_FULL && bus.rsp_ready) state_d = ST_EMPTY;
  end

  // Stage p1: result register, pointer, counter and occupancy state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1 <= ST_EMPTY;
      ptr_p1   <= '0;
      cnt_p1   <= '0;
      sum_p1   <= '0;
      cout_p1  <= 1'b0;
      id_p1    <= '0;
    end else begin
      state_p1 <= state_d;
      if (accept_p0) begin
        sum_p1  <= sum_p0;
        cout_p1 <= cout_p0;
        id_p1   <= grant_p0;
        ptr_p1  <= ptr_after(grant_p0);
        cnt_p1  <= sat_inc(cnt_p1);
      end
    end
  end

  assign bus.rsp_valid = (state_p1 == ST_FULL);
  assign bus.rsp_sum   = sum_p1;
  assign bus.rsp_cout  = cout_p1;
  assign bus.rsp_id    = id_p1;
  assign bus.op_count  = cnt_p1;
endmodule
